// File: rtl/fuzzy_pkg.sv
// fuzzy_pkg: shared states, rule table and arithmetic constants for the fuzzy engine
package fuzzy_pkg;
  typedef enum logic [2:0] {IDLE, FUZZ, RULE, DIV, DONE} state_t;
  localparam int LOW_MAX = 2047;
  localparam int MID_PT = 2048;
  localparam int FULL_SCALE = 4095;
  localparam int DIV_ITERS = 24;
  localparam int NUM_W = 24;
  localparam int DEN_W = 12;
  localparam logic [11:0] RULE_OUT [9] = '{
    12'd0,    12'd1024, 12'd2048,
    12'd1024, 12'd2048, 12'd3072,
    12'd2048, 12'd3072, 12'd4095
  };
endpackage

// File: rtl/fuzzy_engine_if.sv
// fuzzy_engine_if: request/result bundle between the ADC side and the fuzzy engine
interface fuzzy_engine_if #(parameter int DATA_W = 12);
  logic              start;
  logic [DATA_W-1:0] v1;
  logic [DATA_W-1:0] v2;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] out;
  modport master(output start, v1, v2, input busy, done, out);
  modport slave(input start, v1, v2, output busy, done, out);
endinterface

// File: rtl/fuzzy_divider.sv
// fuzzy_divider: sequential restoring divider, one quotient bit per cycle
module fuzzy_divider
  import fuzzy_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] dividend,
  input  logic [DEN_W-1:0] divisor,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);
  logic [NUM_W-1:0] quo_q, quo_d, quo_n;
  logic [DEN_W-1:0] rem_q, rem_d, rem_n, dvs_q, dvs_d;
  logic [DEN_W:0]   rem_s;
  logic [4:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d, ge;
  always_comb begin
    rem_s  = {rem_q, quo_q[NUM_W-1]};
    ge     = rem_s >= {1'b0, dvs_q};
    rem_n  = ge ? DEN_W'(rem_s - {1'b0, dvs_q}) : rem_s[DEN_W-1:0];
    quo_n  = {quo_q[NUM_W-2:0], ge};
    quo_d  = start ? dividend : busy_q ? quo_n : quo_q;
    rem_d  = start ? '0 : busy_q ? rem_n : rem_q;
    dvs_d  = start ? divisor : dvs_q;
    cnt_d  = start ? 5'(DIV_ITERS) : busy_q ? cnt_q - 5'd1 : cnt_q;
    busy_d = start || (busy_q && cnt_q != 5'd1);
  end
  // done marks the cycle whose edge commits the final quotient bit
  assign done     = busy_q && cnt_q == 5'd1;
  assign quotient = quo_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
endmodule

// File: rtl/fuzzy_engine.sv
// fuzzy_engine: two-input Mamdani-style controller with weighted-average defuzzification
module fuzzy_engine
  import fuzzy_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int MU_W   = 8
)
(
  input logic           clk,
  input logic           rst_n,
  fuzzy_engine_if.slave bus
);
  typedef logic [2:0][MU_W-1:0] mu_t;
  localparam logic [DATA_W-1:0] X_LO   = DATA_W'(LOW_MAX);
  localparam logic [DATA_W-1:0] X_MID  = DATA_W'(MID_PT);
  localparam logic [DATA_W-1:0] X_FULL = DATA_W'(FULL_SCALE);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] v1_q, v1_d, v2_q, v2_d, out_q, out_d;
  mu_t               mu1_q, mu1_d, mu2_q, mu2_d;
  logic [NUM_W-1:0]  num_q, num_d, quot;
  logic [DEN_W-1:0]  den_q, den_d;
  logic [1:0]        i_q, i_d, j_q, j_d;
  logic [3:0]        ri;
  logic [MU_W-1:0]   w;
  logic              done_q, done_d, div_start, div_done;
  function automatic mu_t fuzz(input logic [DATA_W-1:0] x);
    logic lo;
    lo = x < X_MID;
    fuzz[0] = lo ? MU_W'((X_LO - x) >> 3) : '0;
    fuzz[1] = MU_W'((lo ? x : X_FULL - x) >> 3);
    fuzz[2] = lo ? '0 : MU_W'((x - X_MID) >> 3);
  endfunction
  assign w  = mu1_q[i_q] < mu2_q[j_q] ? mu1_q[i_q] : mu2_q[j_q];
  assign ri = 4'(i_q) * 4'd3 + 4'(j_q);
  always_comb begin
    state_d   = state_q;
    v1_d      = v1_q;
    v2_d      = v2_q;
    out_d     = out_q;
    mu1_d     = mu1_q;
    mu2_d     = mu2_q;
    num_d     = num_q;
    den_d     = den_q;
    i_d       = i_q;
    j_d       = j_q;
    done_d    = 1'b0;
    div_start = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        v1_d    = bus.v1;
        v2_d    = bus.v2;
        state_d = FUZZ;
      end
      FUZZ: begin
        mu1_d   = fuzz(v1_q);
        mu2_d   = fuzz(v2_q);
        num_d   = '0;
        den_d   = '0;
        i_d     = '0;
        j_d     = '0;
        state_d = RULE;
      end
      RULE: begin
        num_d     = num_q + NUM_W'(w) * NUM_W'(RULE_OUT[ri]);
        den_d     = den_q + DEN_W'(w);
        j_d       = j_q == 2'd2 ? 2'd0 : j_q + 2'd1;
        i_d       = j_q != 2'd2 ? i_q : i_q == 2'd2 ? 2'd0 : i_q + 2'd1;
        // the divider loads the final sums on the same edge the last rule lands
        div_start = i_q == 2'd2 && j_q == 2'd2;
        state_d   = div_start ? DIV : RULE;
      end
      DIV: if (div_done) begin
        out_d   = den_q == '0 ? '0 : DATA_W'(quot);
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  fuzzy_divider u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (num_d),
    .divisor  (den_d),
    .done     (div_done),
    .quotient (quot)
  );
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.out  = out_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      v1_q    <= '0;
      v2_q    <= '0;
      out_q   <= '0;
      mu1_q   <= '0;
      mu2_q   <= '0;
      num_q   <= '0;
      den_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      out_q   <= out_d;
      mu1_q   <= mu1_d;
      mu2_q   <= mu2_d;
      num_q   <= num_d;
      den_q   <= den_d;
      i_q     <= i_d;
      j_q     <= j_d;
      done_q  <= done_d;
    end
endmodule
